// File: rtl/fsbm_search_ctrl.sv
// rtl/fsbm_search_ctrl.sv - full-search candidate sequencer and minimum-SAD tracker
module fsbm_search_ctrl #(
  parameter int N_POS  = 8,
  parameter int PE_LAT = 1,
  parameter int CW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          win_ready,
  output logic          cand_valid,
  output logic [CW-1:0] cand_x,
  output logic [CW-1:0] cand_y,
  output logic          pe_hold,
  input  logic [11:0]   sad_in,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] best_x,
  output logic [CW-1:0] best_y,
  output logic [11:0]   best_sad
);

  localparam int            LAST    = PE_LAT - 1;
  localparam logic [CW-1:0] POS_MAX = CW'(N_POS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [11:0]   min_q, min_d;
  logic [CW-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
  logic [CW-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
  logic [11:0]   best_sad_q, best_sad_d;
  logic          done_q, done_d, busy_q, busy_d, pe_hold_q, pe_hold_d;
  logic          tv_q [PE_LAT];
  logic          tv_d [PE_LAT];
  logic [CW-1:0] tx_q [PE_LAT];
  logic [CW-1:0] tx_d [PE_LAT];
  logic [CW-1:0] ty_q [PE_LAT];
  logic [CW-1:0] ty_d [PE_LAT];
  logic          drain_clear;

  // A candidate goes out whenever we are walking the window and the buffer can serve it
  assign cand_valid = (state_q == S_ISSUE) && win_ready;
  assign cand_x     = x_q;
  assign cand_y     = y_q;
  assign pe_hold    = pe_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_x     = best_x_q;
  assign best_y     = best_y_q;
  assign best_sad   = best_sad_q;

  // Next-state: raster walk, tag shift, strict-less-than minimum tracking, abort override
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    min_d      = min_q;
    min_x_d    = min_x_q;
    min_y_d    = min_y_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    best_sad_d = best_sad_q;

    tv_d[0] = cand_valid;
    tx_d[0] = x_q;
    ty_d[0] = y_q;
    for (int i = 1; i < PE_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      tx_d[i] = tx_q[i-1];
      ty_d[i] = ty_q[i-1];
    end

    // The last stage leaves this cycle, so only earlier stages can keep DRAIN waiting
    drain_clear = 1'b1;
    for (int i = 0; i < PE_LAT - 1; i++) begin
      if (tv_q[i]) drain_clear = 1'b0;
    end

    // Strict compare keeps the earliest candidate on ties
    if (tv_q[LAST] && (sad_in < min_q)) begin
      min_d   = sad_in;
      min_x_d = tx_q[LAST];
      min_y_d = ty_q[LAST];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = '0;
          min_d   = 12'hFFF;
        end
      end
      S_ISSUE: begin
        if (cand_valid) begin
          if (x_q == POS_MAX) begin
            x_d = '0;
            if (y_q == POS_MAX) state_d = S_DRAIN;
            else                y_d     = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Load results from the post-compare values so the final SAD is included
        if (drain_clear) begin
          state_d    = S_DONE;
          best_x_d   = min_x_d;
          best_y_d   = min_y_d;
          best_sad_d = min_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      best_x_d   = best_x_q;
      best_y_d   = best_y_q;
      best_sad_d = best_sad_q;
      for (int i = 0; i < PE_LAT; i++) tv_d[i] = 1'b0;
    end

    done_d    = (state_d == S_DONE);
    busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    pe_hold_d = !busy_d;
  end

  // State, tag pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      min_q      <= 12'hFFF;
      min_x_q    <= '0;
      min_y_q    <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      best_sad_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pe_hold_q  <= 1'b1;
      for (int i = 0; i < PE_LAT; i++) begin
        tv_q[i] <= 1'b0;
        tx_q[i] <= '0;
        ty_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      min_q      <= min_d;
      min_x_q    <= min_x_d;
      min_y_q    <= min_y_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      best_sad_q <= best_sad_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pe_hold_q  <= pe_hold_d;
      for (int i = 0; i < PE_LAT; i++) begin
        tv_q[i] <= tv_d[i];
        tx_q[i] <= tx_d[i];
        ty_q[i] <= ty_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// tb/tb_fsbm_search_ctrl.sv - randomized self-checking bench for fsbm_search_ctrl
module tb_fsbm_search_ctrl;

  localparam int N   = 8;
  localparam int LAT = 1;
  localparam int CW  = 3;
  localparam int N2  = N * N;

  logic          clk, reset, start, abort, win_ready;
  logic          cand_valid, pe_hold, busy, done;
  logic [CW-1:0] cand_x, cand_y, best_x, best_y;
  logic [11:0]   sad_in, best_sad;

  int n_cmp, n_bad, cyc;
  int pb_x, pb_y, pb_sad;
  int tab  [N2];
  int hist [1024];

  fsbm_search_ctrl #(.N_POS(N), .PE_LAT(LAT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .win_ready(win_ready),
    .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y), .pe_hold(pe_hold),
    .sad_in(sad_in), .busy(busy), .done(done),
    .best_x(best_x), .best_y(best_y), .best_sad(best_sad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic check_best_hold();
    check("best_x_hold", best_x, pb_x);
    check("best_y_hold", best_y, pb_y);
    check("best_sad_hold", best_sad, pb_sad);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk); cyc++;
      start = 0; abort = 0;
      win_ready = 1'($urandom_range(0, 1));
      sad_in = 12'($urandom_range(0, 4095));
      #1;
      check("idle_cand_valid", cand_valid, 0);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_pe_hold", pe_hold, 1);
      check_best_hold();
    end
  endtask

  // sad_mode: 0 = |x-5|+|y-2|+10, 1 = constant 100, 2 = random full range, 3 = random small (ties)
  // stall_mode: 0 = none, 1 = 3 bubbles after candidates 10 and 40, 2 = random
  task automatic do_search(input int sad_mode, input int stall_mode, input int abort_at,
                           input bit poke_start, input bit reset_in_drain, input int want_done);
    int issued, done_cyc, stall_left, phase, idx, obs_done, n_valid;
    int eb_x, eb_y, eb_sad;
    bit finished, exp_cv, exp_done;

    for (int i = 0; i < N2; i++) begin
      case (sad_mode)
        0:       tab[i] = absd(i % N, 5) + absd(i / N, 2) + 10;
        1:       tab[i] = 100;
        2:       tab[i] = $urandom_range(0, 4080);
        default: tab[i] = $urandom_range(0, 15);
      endcase
    end
    eb_sad = 4095; eb_x = 0; eb_y = 0;
    for (int i = 0; i < N2; i++) begin
      if (tab[i] < eb_sad) begin
        eb_sad = tab[i]; eb_x = i % N; eb_y = i / N;
      end
    end
    for (int i = 0; i < 1024; i++) hist[i] = -1;

    issued = 0; phase = 1; done_cyc = -1; stall_left = 0; obs_done = -1; n_valid = 0;
    finished = 0;
    cyc = 0; start = 1; abort = 0;
    for (int g = 0; g < 1000 && !finished; g++) begin
      @(posedge clk); @(negedge clk); cyc++;
      start = 0; abort = 0;
      if (stall_left > 0) begin
        win_ready = 0; stall_left--;
      end else if (stall_mode == 2) begin
        win_ready = ($urandom_range(0, 3) != 0);
      end else begin
        win_ready = 1;
      end
      #1;
      exp_cv = (phase == 1) && win_ready;
      check("cand_valid", cand_valid, exp_cv);
      if (cand_valid) n_valid++;
      if (phase == 1) begin
        check("cand_x", cand_x, issued % N);
        check("cand_y", cand_y, issued / N);
      end
      exp_done = (phase == 2) && (cyc == done_cyc);
      check("done", done, exp_done);
      if (done && obs_done < 0) obs_done = cyc;
      check("busy", busy, (phase != 0) && !exp_done);
      check("pe_hold", pe_hold, !((phase != 0) && !exp_done));

      if (reset_in_drain && phase == 2 && !exp_done) begin
        reset = 1;
        #1;
        check("rst_cand_valid", cand_valid, 0);
        check("rst_cand_x", cand_x, 0);
        check("rst_cand_y", cand_y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pe_hold", pe_hold, 1);
        pb_x = 0; pb_y = 0; pb_sad = 0;
        check_best_hold();
        @(negedge clk);
        reset = 0;
        finished = 1;
      end else begin
        if (exp_done) begin
          check("best_x", best_x, eb_x);
          check("best_y", best_y, eb_y);
          check("best_sad", best_sad, eb_sad);
          check("issue_count", n_valid, N2);
          if (want_done >= 0) check("done_cycle", obs_done, want_done);
          pb_x = eb_x; pb_y = eb_y; pb_sad = eb_sad;
          finished = 1;
        end else begin
          check_best_hold();
        end
        if (exp_cv) begin
          hist[cyc] = issued;
          issued++;
          if (stall_mode == 1 && (issued == 10 || issued == 40)) stall_left = 3;
          if (issued == N2) begin
            phase = 2;
            done_cyc = cyc + LAT + 1;
          end
        end
        idx = (cyc >= LAT) ? hist[cyc - LAT] : -1;
        sad_in = (idx >= 0) ? 12'(tab[idx]) : 12'($urandom_range(0, 4095));
        if (poke_start && (cyc == 5 || exp_done)) start = 1;
        if (abort_at >= 0 && exp_cv && issued == abort_at) begin
          abort = 1;
          finished = 1;
        end
      end
    end
    if (!finished) check("search_timeout", 0, 1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    clk = 0; reset = 0; start = 0; abort = 0; win_ready = 0; sad_in = 0;
    pb_x = 0; pb_y = 0; pb_sad = 0;
    #2 reset = 1;
    @(negedge clk); #1;
    check("reset_cand_valid", cand_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pe_hold", pe_hold, 1);
    check_best_hold();
    reset = 0;
    idle_check(2);

    do_search(0, 0, -1, 0, 0, N2 + LAT + 1); idle_check(3);
    do_search(1, 0, -1, 0, 0, N2 + LAT + 1); idle_check(2);
    do_search(0, 1, -1, 0, 0, N2 + LAT + 7); idle_check(2);
    do_search(2, 2, 20, 0, 0, -1);           idle_check(4);
    do_search(0, 0, -1, 0, 0, N2 + LAT + 1); idle_check(2);
    do_search(2, 0, -1, 1, 0, N2 + LAT + 1); idle_check(3);
    do_search(3, 2, -1, 0, 1, -1);           idle_check(2);
    do_search(2, 0, -1, 0, 0, N2 + LAT + 1); idle_check(2);
    for (int r = 0; r < 3; r++) begin
      do_search(3, 2, -1, 0, 0, -1);
      idle_check(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
